aes_inv_key_schedule: RTL and testbench

//   Iterative AES-128 key schedule for the decryption datapath. Produces round keys
//   in reverse order (round 10 down to round 0), one key per valid/ready handshake.

---
 rtl/aes_inv_key_schedule.sv | 160 ++++++++++++++++
 tb/tb_aes_inv_key_schedule.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_schedule.sv
// rtl/aes_inv_key_schedule.sv - AES-128 round key generator emitting round 10 down to round 0
module forward_substitution_box (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // S-box computed as GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] b;
        t = gf_mul(gf_mul(x, x), x);              // x^3
        t = gf_mul(gf_mul(t, t), x);              // x^7
        t = gf_mul(gf_mul(t, t), x);              // x^15
        t = gf_mul(gf_mul(t, t), x);              // x^31
        t = gf_mul(gf_mul(t, t), x);              // x^63
        t = gf_mul(gf_mul(t, t), x);              // x^127
        b = gf_mul(t, t);                         // x^254
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign y = sbox(a);
endmodule

module aes_inv_key_schedule #(
    parameter int NUM_ROUNDS = 10,
    parameter bit FWD_ENABLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_is_last,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         done
);
    localparam logic [3:0] ROUND_TOP = 4'(NUM_ROUNDS);
    localparam logic [3:0] LAST_CNT  = 4'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

    state_t       state;
    logic [127:0] key_reg;
    logic [3:0]   cnt;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0: rcon = 8'h01;
            4'd1: rcon = 8'h02;
            4'd2: rcon = 8'h04;
            4'd3: rcon = 8'h08;
            4'd4: rcon = 8'h10;
            4'd5: rcon = 8'h20;
            4'd6: rcon = 8'h40;
            4'd7: rcon = 8'h80;
            4'd8: rcon = 8'h1b;
            4'd9: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] sbox_in, rot_word, sub_word, rc_word;
    logic [127:0] fwd_key, inv_key;
    logic [3:0]  rc_idx;

    assign {w0, w1, w2, w3} = key_reg;

    // One S-box set serves both directions: w3 going forward, recovered w3 going back
    assign sbox_in  = (state == EMIT) ? (w3 ^ w2) : w3;
    assign rot_word = {sbox_in[23:0], sbox_in[31:24]};
    assign rc_idx   = (state == EMIT) ? (rk_round - 4'd1) : cnt;
    assign rc_word  = {rcon(rc_idx), 24'h000000};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        forward_substitution_box u_sbox (
            .a (rot_word[8*i +: 8]),
            .y (sub_word[8*i +: 8])
        );
    end

    logic [31:0] f0, f1, f2, f3;
    assign f0 = w0 ^ sub_word ^ rc_word;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};

    assign inv_key = {w0 ^ sub_word ^ rc_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    assign rk_out = rk_valid ? key_reg : 128'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            key_reg  <= 128'h0;
            cnt      <= 4'd0;
            rk_round <= 4'd0;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_reg <= key_in;
                        busy    <= 1'b1;
                        if (FWD_ENABLE && !key_is_last) begin
                            state <= FWD;
                            cnt   <= 4'd0;
                        end else begin
                            state    <= EMIT;
                            rk_valid <= 1'b1;
                            rk_round <= ROUND_TOP;
                        end
                    end
                end
                FWD: begin
                    key_reg <= fwd_key;
                    cnt     <= cnt + 4'd1;
                    if (cnt == LAST_CNT) begin
                        state    <= EMIT;
                        rk_valid <= 1'b1;
                        rk_round <= ROUND_TOP;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (rk_round != 4'd0) begin
                            key_reg  <= inv_key;
                            rk_round <= rk_round - 4'd1;
                        end else begin
                            state    <= IDLE;
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb/tb_aes_inv_key_schedule.sv - scoreboard bench for aes_inv_key_schedule
module tb_aes_inv_key_schedule;
    logic         clk = 1'b0;
    logic         rst, start, key_is_last, rk_ready;
    logic [127:0] key_in;
    logic         busy, rk_valid, done;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;

    aes_inv_key_schedule #(.NUM_ROUNDS(10), .FWD_ENABLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .key_is_last(key_is_last),
        .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out),
        .rk_round(rk_round), .done(done)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] CK   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] Z10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         sb_e;
    logic [127:0] seen [0:10];
    logic [7:0]   sbox_m [0:255];
    logic [127:0] rk_m [0:10];

    // Reference S-box from the multiplicative generator walk
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_m[p] = x ^ 8'h63;
        end
        sbox_m[0] = 8'h63;
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0]  t, a, b, c, d;
        logic [7:0]   rc;
        logic [127:0] prev;
        rk_m[0] = k;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            prev = rk_m[r-1];
            t = {prev[23:0], prev[31:24]};
            t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
            t = t ^ {rc, 24'h0};
            a = prev[127:96] ^ t;
            b = prev[95:64] ^ a;
            c = prev[63:32] ^ b;
            d = prev[31:0] ^ c;
            rk_m[r] = {a, b, c, d};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
    endtask

    task automatic push_run();
        for (int r = 10; r >= 0; r--) sb_q.push_back({4'(r), rk_m[r]});
    endtask

    always @(negedge clk) begin
        if (!rst && rk_valid && rk_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_extra_key", 128'(sb_q.size()), 128'd1);
            end else begin
                sb_e = sb_q.pop_front();
                check("rk_round", 128'(rk_round), 128'(sb_e.rnd));
                check("rk_out", rk_out, sb_e.key);
                if (rk_round <= 4'd10) seen[rk_round] = rk_out;
            end
        end
    end

    task automatic do_start(input logic [127:0] k, input logic last);
        @(posedge clk); #1;
        start = 1'b1; key_in = k; key_is_last = last;
        @(posedge clk); #1;
        start = 1'b0; key_in = '0;
    endtask

    task automatic wait_done(output int cycles, output logic got);
        cycles = 0;
        got = 1'b0;
        while (cycles < 100 && !got) begin
            @(negedge clk);
            cycles++;
            got = done;
        end
    endtask

    task automatic run_vector_last();
        int cyc;
        logic got;
        expand(CK);
        push_run();
        rk_ready = 1'b1;
        do_start(RK10, 1'b1);
        check("first_valid", 128'(rk_valid), 128'd1);
        check("first_round", 128'(rk_round), 128'd10);
        wait_done(cyc, got);
        check("done_seen", 128'(got), 128'd1);
        check("done_cycle", 128'(cyc), 128'd12);
        check("sb_drained", 128'(sb_q.size()), 128'd0);
        check("round9_vec", seen[9], RK9);
        check("round1_vec", seen[1], RK1);
        check("round0_vec", seen[0], CK);
    endtask

    initial begin
        int cyc, bad;
        logic got;
        logic [127:0] rk;
        build_sbox();
        rst = 1'b1; start = 1'b0; key_is_last = 1'b0; rk_ready = 1'b0; key_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_valid", 128'(rk_valid), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_rk_out", rk_out, 128'd0);
        check("rst_rk_round", 128'(rk_round), 128'd0);
        rst = 1'b0;

        run_vector_last();

        // cipher key: ten cycles of forward expansion before the first key
        expand(CK);
        push_run();
        do_start(CK, 1'b0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rk_valid || !busy) bad++;
        end
        check("fwd_quiet", 128'(bad), 128'd0);
        @(negedge clk);
        check("fwd_first_valid", 128'(rk_valid), 128'd1);
        check("fwd_first_round", 128'(rk_round), 128'd10);
        check("fwd_first_key", rk_out, RK10);
        wait_done(cyc, got);
        check("fwd_done_cycle", 128'(cyc), 128'd11);
        check("fwd_sb_drained", 128'(sb_q.size()), 128'd0);

        // backpressure held at round 9
        expand(CK);
        push_run();
        do_start(RK10, 1'b1);
        @(posedge clk); #1;
        rk_ready = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rk_out !== RK9 || rk_round !== 4'd9 || !rk_valid) bad++;
        end
        check("bp_hold", 128'(bad), 128'd0);
        @(posedge clk); #1;
        rk_ready = 1'b1;
        wait_done(cyc, got);
        check("bp_done_seen", 128'(got), 128'd1);
        check("bp_sb_drained", 128'(sb_q.size()), 128'd0);

        // start during a run is ignored
        expand(CK);
        push_run();
        do_start(RK10, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("ign_round6", 128'(rk_round), 128'd6);
        start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom}; key_is_last = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, got);
        check("ign_done_cycle", 128'(cyc), 128'd7);
        check("ign_sb_drained", 128'(sb_q.size()), 128'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rk_valid || busy) bad++;
        end
        check("ign_no_restart", 128'(bad), 128'd0);

        // reset at round 5 aborts the run
        expand(CK);
        push_run();
        do_start(RK10, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_round5", 128'(rk_round), 128'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        check("abort_valid", 128'(rk_valid), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_rk_out", rk_out, 128'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rk_valid || busy || done) bad++;
        end
        check("abort_silent", 128'(bad), 128'd0);
        run_vector_last();

        // all-zero cipher key
        expand(128'h0);
        push_run();
        do_start(128'h0, 1'b0);
        wait_done(cyc, got);
        check("zero_done_seen", 128'(got), 128'd1);
        check("zero_round10", seen[10], Z10);
        check("zero_round0", seen[0], 128'h0);

        // random keys, both key types, random consumer stalls
        for (int n = 0; n < 4; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            expand(rk);
            push_run();
            rk_ready = 1'b1;
            do_start(n[0] ? rk_m[10] : rk, n[0]);
            got = 1'b0;
            for (int i = 0; i < 300 && !got; i++) begin
                @(posedge clk); #1;
                got = done;
                rk_ready = 1'($urandom_range(0, 1));
            end
            rk_ready = 1'b1;
            check("rand_done_seen", 128'(got), 128'd1);
            check("rand_sb_drained", 128'(sb_q.size()), 128'd0);
            check("rand_round0", seen[0], rk);
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
